// File: rtl/intdiv_frontend_pkg.sv
// Shared types and width-dependent constants for the divider request front-end.
package intdiv_frontend_pkg;

  typedef enum logic [2:0] {IDLE, FAST, ISSUE, WAIT, RESP} fe_state_t;
  typedef enum logic [2:0] {NONE, DIV0, OVF, ONE, SMALL} fast_kind_t;

  localparam int MAX_W = 64;

  // Most negative two's-complement value of a w-bit word, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] min_of(int w);
    return MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] all_ones_of(int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/intdiv_frontend_if.sv
// Request, divider and response signals of the divide front-end.
interface intdiv_frontend_if #(
  parameter int D_W   = 64,
  parameter int TAG_W = 4
);
  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_signed_i;
  logic [D_W-1:0]   req_dividend_i;
  logic [D_W-1:0]   req_divisor_i;
  logic [TAG_W-1:0] req_tag_i;

  logic             div_flush_o;
  logic             div_start_valid_o;
  logic             div_start_ready_i;
  logic             div_signed_op_o;
  logic [D_W-1:0]   div_dividend_o;
  logic [D_W-1:0]   div_divisor_o;
  logic             div_finish_valid_i;
  logic             div_finish_ready_o;
  logic [D_W-1:0]   div_quotient_i;
  logic [D_W-1:0]   div_remainder_i;
  logic             div_divisor_is_zero_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [D_W-1:0]   rsp_quotient_o;
  logic [D_W-1:0]   rsp_remainder_o;
  logic             rsp_divisor_is_zero_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             rsp_fast_o;

  modport slave (
    input  flush_i, req_valid_i, req_signed_i, req_dividend_i, req_divisor_i, req_tag_i,
           div_start_ready_i, div_finish_valid_i, div_quotient_i, div_remainder_i,
           div_divisor_is_zero_i, rsp_ready_i,
    output req_ready_o, div_flush_o, div_start_valid_o, div_signed_op_o, div_dividend_o,
           div_divisor_o, div_finish_ready_o, rsp_valid_o, rsp_quotient_o, rsp_remainder_o,
           rsp_divisor_is_zero_o, rsp_tag_o, rsp_fast_o
  );

  modport master (
    output flush_i, req_valid_i, req_signed_i, req_dividend_i, req_divisor_i, req_tag_i,
           div_start_ready_i, div_finish_valid_i, div_quotient_i, div_remainder_i,
           div_divisor_is_zero_i, rsp_ready_i,
    input  req_ready_o, div_flush_o, div_start_valid_o, div_signed_op_o, div_dividend_o,
           div_divisor_o, div_finish_ready_o, rsp_valid_o, rsp_quotient_o, rsp_remainder_o,
           rsp_divisor_is_zero_o, rsp_tag_o, rsp_fast_o
  );
endinterface

// File: rtl/intdiv_fast_path_detect.sv
// Classifies a divide request as trivial and produces its result without the divider.
module intdiv_fast_path_detect
  import intdiv_frontend_pkg::*;
#(
  parameter int D_W = 64
) (
  input  logic           signed_op,
  input  logic [D_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output fast_kind_t     kind,
  output logic [D_W-1:0] q,
  output logic [D_W-1:0] r,
  output logic           dz
);
  localparam logic [D_W-1:0] MIN      = D_W'(min_of(D_W));
  localparam logic [D_W-1:0] ALL_ONES = D_W'(all_ones_of(D_W));

  // Priority order matters: a zero divisor wins over every other class.
  always_comb begin
    kind = NONE;
    q    = '0;
    r    = '0;
    dz   = 1'b0;
    if (divisor == '0) begin
      kind = DIV0;
      q    = ALL_ONES;
      r    = dividend;
      dz   = 1'b1;
    end else if (signed_op && dividend == MIN && divisor == ALL_ONES) begin
      kind = OVF;
      q    = MIN;
    end else if (divisor == D_W'(1)) begin
      kind = ONE;
      q    = dividend;
    end else if (!signed_op && dividend < divisor) begin
      kind = SMALL;
      r    = dividend;
    end
  end
endmodule

// File: rtl/intdiv_frontend.sv
// Single-entry request front-end: answers trivial divides locally, forwards the rest to the divider.
module intdiv_frontend
  import intdiv_frontend_pkg::*;
#(
  parameter int D_W   = 64,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  intdiv_frontend_if.slave bus
);
  fe_state_t        state;
  fast_kind_t       kind;
  logic [D_W-1:0]   fq, fr;
  logic             fdz;
  logic             op_signed;
  logic [D_W-1:0]   op_dividend, op_divisor;
  logic [D_W-1:0]   res_q, res_r;
  logic             res_dz, res_fast;
  logic [TAG_W-1:0] res_tag;
  logic             req_hs, rsp_hs, holding;

  intdiv_fast_path_detect #(.D_W(D_W)) u_detect (
    .signed_op (bus.req_signed_i),
    .dividend  (bus.req_dividend_i),
    .divisor   (bus.req_divisor_i),
    .kind      (kind),
    .q         (fq),
    .r         (fr),
    .dz        (fdz)
  );

  assign holding         = (state == FAST) || (state == RESP);
  assign bus.req_ready_o = !bus.flush_i && ((state == IDLE) || (holding && bus.rsp_ready_i));
  assign req_hs          = bus.req_valid_i && bus.req_ready_o;
  assign rsp_hs          = holding && bus.rsp_ready_i;

  assign bus.div_flush_o        = bus.flush_i && ((state == ISSUE) || (state == WAIT));
  assign bus.div_start_valid_o  = (state == ISSUE);
  assign bus.div_signed_op_o    = op_signed;
  assign bus.div_dividend_o     = op_dividend;
  assign bus.div_divisor_o      = op_divisor;
  assign bus.div_finish_ready_o = (state == WAIT);

  assign bus.rsp_valid_o           = holding;
  assign bus.rsp_quotient_o        = res_q;
  assign bus.rsp_remainder_o       = res_r;
  assign bus.rsp_divisor_is_zero_o = res_dz;
  assign bus.rsp_tag_o             = res_tag;
  assign bus.rsp_fast_o            = res_fast;

  // req_hs can only fire in IDLE/FAST/RESP, so it is handled ahead of the per-state moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_signed   <= 1'b0;
      op_dividend <= '0;
      op_divisor  <= '0;
      res_q       <= '0;
      res_r       <= '0;
      res_dz      <= 1'b0;
      res_fast    <= 1'b0;
      res_tag     <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
    end else if (req_hs) begin
      res_tag <= bus.req_tag_i;
      if (kind != NONE) begin
        state    <= FAST;
        res_q    <= fq;
        res_r    <= fr;
        res_dz   <= fdz;
        res_fast <= 1'b1;
      end else begin
        state       <= ISSUE;
        op_signed   <= bus.req_signed_i;
        op_dividend <= bus.req_dividend_i;
        op_divisor  <= bus.req_divisor_i;
      end
    end else begin
      case (state)
        FAST, RESP: if (rsp_hs) state <= IDLE;
        ISSUE:      if (bus.div_start_ready_i) state <= WAIT;
        WAIT: begin
          if (bus.div_finish_valid_i) begin
            state    <= RESP;
            res_q    <= bus.div_quotient_i;
            res_r    <= bus.div_remainder_i;
            res_dz   <= bus.div_divisor_is_zero_i;
            res_fast <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_intdiv_frontend.sv
// Scoreboard bench: randomized requests, a behavioural divider stand-in and a reference model.
module tb_intdiv_frontend;
  localparam int D_W   = 32;
  localparam int TAG_W = 4;
  localparam int N_RAND = 3000;
  typedef logic [D_W-1:0] word_t;
  typedef struct {
    word_t            q;
    word_t            r;
    logic             dz;
    logic             fast;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  intdiv_frontend_if #(.D_W(D_W), .TAG_W(TAG_W)) bus();
  intdiv_frontend #(.D_W(D_W), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   checks = 0, failures = 0;
  int   pushes = 0, rsp_count = 0, starts = 0;
  int   rsp_mode = 2;      // 0 random ready, 1 always ready, 2 never ready
  int   div_lat_max = 3;
  exp_t sbq[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain truncating integer division as the divider computes it.
  function automatic void ref_div(logic s, word_t a, word_t b, output word_t q, output word_t r);
    longint x, y;
    if (s) begin x = longint'($signed(a)); y = longint'($signed(b)); end
    else begin x = longint'({32'b0, a}); y = longint'({32'b0, b}); end
    q = word_t'(x / y);
    r = word_t'(x % y);
  endfunction

  function automatic exp_t model(logic s, word_t a, word_t b, logic [TAG_W-1:0] t);
    exp_t e;
    e.tag = t; e.dz = 1'b0; e.fast = 1'b1;
    if (b == 0) begin e.q = '1; e.r = a; e.dz = 1'b1; end
    else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.q = a; e.r = 0; end
    else if (b == 1) begin e.q = a; e.r = 0; end
    else if (!s && a < b) begin e.q = 0; e.r = a; end
    else begin e.fast = 1'b0; ref_div(s, a, b, e.q, e.r); end
    return e;
  endfunction

  // Divider stand-in: random start acceptance and latency, drops work on flush.
  initial begin
    bit busy = 0, fin = 0;
    int cnt = 0;
    word_t dq = 0, dr = 0;
    logic ddz = 0;
    bus.div_start_ready_i = 0; bus.div_finish_valid_i = 0;
    bus.div_quotient_i = 0; bus.div_remainder_i = 0; bus.div_divisor_is_zero_i = 0;
    forever begin
      @(negedge clk);
      if (bus.div_flush_o) begin busy = 0; fin = 0; end
      else if (!busy && bus.div_start_valid_o && bus.div_start_ready_i) begin
        busy = 1; fin = 0; cnt = $urandom_range(0, div_lat_max);
        ddz = (bus.div_divisor_o == 0);
        if (!ddz) ref_div(bus.div_signed_op_o, bus.div_dividend_o, bus.div_divisor_o, dq, dr);
      end else if (busy && fin && bus.div_finish_ready_o) begin busy = 0; fin = 0; end
      else if (busy && !fin) begin if (cnt == 0) fin = 1; else cnt--; end
      @(posedge clk); #1;
      bus.div_start_ready_i  = !busy && ($urandom_range(0, 2) != 0);
      bus.div_finish_valid_i = fin;
      bus.div_quotient_i = dq; bus.div_remainder_i = dr; bus.div_divisor_is_zero_i = ddz;
    end
  end

  initial begin
    bus.rsp_ready_i = 0;
    forever begin
      @(posedge clk); #2;
      case (rsp_mode)
        0:       bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
        1:       bus.rsp_ready_i = 1;
        default: bus.rsp_ready_i = 0;
      endcase
    end
  end

  always @(negedge clk) if (bus.div_start_valid_o && bus.div_start_ready_i) starts++;

  // Monitor: every cycle a response is presented it must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid_o) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected: got tag %0d expected no response", bus.rsp_tag_o);
      end else begin
        e = sbq[0];
        chk("rsp_q", bus.rsp_quotient_o, e.q);
        chk("rsp_r", bus.rsp_remainder_o, e.r);
        chk("rsp_dz", bus.rsp_divisor_is_zero_o, e.dz);
        chk("rsp_fast", bus.rsp_fast_o, e.fast);
        chk("rsp_tag", bus.rsp_tag_o, e.tag);
        if (bus.rsp_ready_i) begin void'(sbq.pop_front()); rsp_count++; end
      end
    end
  end

  task automatic send(logic s, word_t a, word_t b, logic [TAG_W-1:0] t);
    bit ok = 0;
    bus.req_signed_i = s; bus.req_dividend_i = a; bus.req_divisor_i = b; bus.req_tag_i = t;
    bus.req_valid_i = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        sbq.push_back(model(s, a, b, t)); pushes++; ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.req_valid_i = 0;
    if (!ok) begin checks++; failures++; $display("FAIL req_timeout: got no accept expected accept tag %0d", t); end
  endtask

  task automatic drain();
    for (int c = 0; c < 2000 && sbq.size() != 0; c++) begin @(posedge clk); #1; end
    chk("drain_empty", sbq.size(), 0);
  endtask

  function automatic word_t pick_divisor();
    case ($urandom_range(0, 9))
      0:       return 0;
      1:       return 1;
      2:       return '1;
      3:       return word_t'($urandom_range(2, 20));
      default: return word_t'($urandom);
    endcase
  endfunction

  function automatic word_t pick_dividend();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return word_t'($urandom_range(0, 50));
      default: return word_t'($urandom);
    endcase
  endfunction

  initial begin
    int s0;
    bit seen;
    bus.flush_i = 0; bus.req_valid_i = 0; bus.req_signed_i = 0;
    bus.req_dividend_i = 0; bus.req_divisor_i = 0; bus.req_tag_i = 0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid_o, 0);
    chk("reset_start_valid", bus.div_start_valid_o, 0);
    chk("reset_finish_ready", bus.div_finish_ready_o, 0);
    chk("reset_div_flush", bus.div_flush_o, 0);
    chk("reset_rsp_q", bus.rsp_quotient_o, 0);
    chk("reset_rsp_tag", bus.rsp_tag_o, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    // Divide by zero: 1-cycle fast response, held 20 cycles, divider untouched.
    s0 = starts;
    send(0, 32'h0000_1234, 0, 1);
    @(negedge clk);
    chk("fast_latency", bus.rsp_valid_o, 1);
    repeat (20) @(posedge clk);
    #1; rsp_mode = 1;
    drain();
    chk("div0_no_start", starts - s0, 0);

    rsp_mode = 0;
    send(1, 32'h8000_0000, 32'hFFFF_FFFF, 2); drain();
    send(0, 5, 9, 3); drain();
    send(1, 100, 1, 4); drain();
    send(1, 32'hFFFF_FF9C, 7, 5); drain();

    // Back-to-back fast requests: each accept coincides with the previous rsp handshake.
    rsp_mode = 1;
    @(posedge clk); #1;
    bus.req_valid_i = 1;
    for (int k = 0; k < 4; k++) begin
      bus.req_signed_i = 0; bus.req_dividend_i = word_t'(k); bus.req_divisor_i = 9;
      bus.req_tag_i = TAG_W'(k + 8);
      @(negedge clk);
      chk("b2b_ready", bus.req_ready_o, 1);
      if (k > 0) chk("b2b_no_bubble", bus.rsp_valid_o, 1);
      sbq.push_back(model(0, word_t'(k), 9, TAG_W'(k + 8))); pushes++;
      @(posedge clk); #1;
    end
    bus.req_valid_i = 0;
    rsp_mode = 2;
    repeat (20) @(posedge clk);
    #1; rsp_mode = 1;
    drain();

    // Flush while the divider is busy: request is dropped, next one completes.
    div_lat_max = 15;
    send(1, 1000, 7, 6);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.div_finish_ready_o) begin seen = 1; break; end
    end
    chk("flush_reached_wait", seen, 1);
    @(posedge clk); #1; bus.flush_i = 1;
    @(negedge clk);
    chk("flush_div_flush_on", bus.div_flush_o, 1);
    chk("flush_req_ready", bus.req_ready_o, 0);
    @(posedge clk); #1; bus.flush_i = 0;
    void'(sbq.pop_back()); pushes--;
    @(negedge clk);
    chk("flush_div_flush_off", bus.div_flush_o, 0);
    chk("flush_rsp_dropped", bus.rsp_valid_o, 0);
    repeat (20) @(posedge clk);
    #1; div_lat_max = 3;
    send(1, 32'hFFFF_FF9C, 7, 7); drain();

    // Random mix against the reference model.
    rsp_mode = 0;
    for (int i = 0; i < N_RAND && failures < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(1'($urandom_range(0, 1)), pick_dividend(), pick_divisor(), TAG_W'($urandom));
    end
    rsp_mode = 1;
    drain();
    chk("rsp_total", rsp_count, pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
